// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: multiplexed seven-segment driver with hex/decimal conversion, blanking and overflow dashes
// Ports: clk/rst (async, active-low); value/mode/dp_in/lzb sampled on the update pulse;
//        busy/done/overflow report conversion state; sseg_an/sseg_sig drive the board pins (active-low)
module sseg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int VALUE_W     = 13,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  mode,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic                  lzb,
  input  logic                  update,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] sseg_an,
  output logic [7:0]            sseg_sig
);
  localparam int DW = 4 * NUM_DIGITS;
  localparam int XW = VALUE_W + DW;
  localparam int PW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(VALUE_W + 1);

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t                state_q, state_d;
  logic [VALUE_W-1:0]    val_q, val_d, pval_q, pval_d;
  logic                  mode_q, mode_d, pmode_q, pmode_d;
  logic [NUM_DIGITS-1:0] dp_q, dp_d, pdp_q, pdp_d;
  logic                  lzb_q, lzb_d, plzb_q, plzb_d, pend_q, pend_d;
  logic [DW-1:0]         bcd_q, bcd_d, disp_q, disp_d;
  logic                  ovf_q, ovf_d, overflow_q, overflow_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0] ddp_q, ddp_d, blank_q, blank_d, an_q, an_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [7:0]            sig_q, sig_d;

  logic [DW-1:0]         adj;
  logic [XW-1:0]         vx;
  logic [NUM_DIGITS-1:0] lz;
  logic                  nz, start, use_in, wrap, on;
  logic [3:0]            dig;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    val_d      = val_q;
    mode_d     = mode_q;
    dp_d       = dp_q;
    lzb_d      = lzb_q;
    pval_d     = pval_q;
    pmode_d    = pmode_q;
    pdp_d      = pdp_q;
    plzb_d     = plzb_q;
    pend_d     = pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    disp_d     = disp_q;
    ddp_d      = ddp_q;
    blank_d    = blank_q;
    overflow_d = overflow_q;
    adj        = bcd_q;
    vx         = XW'(val_q);
    lz         = '0;
    nz         = 1'b0;
    start      = 1'b0;
    use_in     = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++)
      adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    // lz[i] marks digits with nothing but zeros from i upward; digit 0 is never blanked
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      nz    = nz | (bcd_q[4*i +: 4] != 4'd0);
      lz[i] = ~nz;
    end
    // requests arriving mid-conversion park here; the newest one overwrites older ones
    if (update && state_q != IDLE) begin
      pval_d  = value;
      pmode_d = mode;
      pdp_d   = dp_in;
      plzb_d  = lzb;
      pend_d  = 1'b1;
    end
    case (state_q)
      IDLE: start = update;
      CONV: begin
        if (mode_q) begin
          bcd_d = {adj[DW-2:0], val_q[VALUE_W-1]};
          ovf_d = ovf_q | adj[DW-1];
          val_d = val_q << 1;
          cnt_d = cnt_q + CW'(1);
          state_d = cnt_q == CW'(VALUE_W - 1) ? LOAD : CONV;
        end else begin
          bcd_d   = vx[DW-1:0];
          ovf_d   = |vx[XW-1:DW];
          state_d = LOAD;
        end
      end
      LOAD: begin
        disp_d     = bcd_q;
        overflow_d = ovf_q;
        ddp_d      = ovf_q ? '0 : dp_q;
        blank_d    = (ovf_q || !lzb_q) ? '0 : lz;
        state_d    = IDLE;
        start      = update | pend_q;
        use_in     = update;
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d = CONV;
      pend_d  = 1'b0;
      val_d   = use_in ? value : pval_q;
      mode_d  = use_in ? mode : pmode_q;
      dp_d    = use_in ? dp_in : pdp_q;
      lzb_d   = use_in ? lzb : plzb_q;
      bcd_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end
    busy_d  = state_d != IDLE;
    done_d  = state_d == LOAD;
    wrap    = presc_q == PW'(REFRESH_DIV - 1);
    presc_d = wrap ? '0 : presc_q + PW'(1);
    idx_d   = !wrap ? idx_q : idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + IW'(1);
    dig     = disp_q[4*int'(idx_q) +: 4];
    on      = presc_q >= PW'(BLANK_CYC) && !blank_q[idx_q];
    an_d    = '1;
    if (on) an_d[idx_q] = 1'b0;
    sig_d   = !on ? 8'hFF : overflow_q ? 8'hBF : {~ddp_q[idx_q], seg7(dig)};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      val_q      <= '0;
      mode_q     <= 1'b0;
      dp_q       <= '0;
      lzb_q      <= 1'b0;
      pval_q     <= '0;
      pmode_q    <= 1'b0;
      pdp_q      <= '0;
      plzb_q     <= 1'b0;
      pend_q     <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      disp_q     <= '0;
      ddp_q      <= '0;
      blank_q    <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      presc_q    <= '0;
      idx_q      <= '0;
      an_q       <= '1;
      sig_q      <= 8'hFF;
    end else begin
      state_q    <= state_d;
      val_q      <= val_d;
      mode_q     <= mode_d;
      dp_q       <= dp_d;
      lzb_q      <= lzb_d;
      pval_q     <= pval_d;
      pmode_q    <= pmode_d;
      pdp_q      <= pdp_d;
      plzb_q     <= plzb_d;
      pend_q     <= pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
      ddp_q      <= ddp_d;
      blank_q    <= blank_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      sig_q      <= sig_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign sseg_an  = an_q;
  assign sseg_sig = sig_q;
endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb_sseg_scan_ctrl: vector table, corner sequences and randomized model checks for sseg_scan_ctrl
module tb_sseg_scan_ctrl;
  localparam logic [6:0] SEGTAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam int NL = 256;

  typedef struct packed {
    logic            m;
    logic [12:0]     v;
    logic [3:0]      dp;
    logic            l;
    logic [3:0][8:0] e;
  } vec_t;

  logic        clk, rst, mode, lzb, update_a, update_b;
  logic [12:0] value_a;
  logic [7:0]  value_b;
  logic [3:0]  dp_a, an_a;
  logic [1:0]  dp_b, an_b;
  logic [7:0]  sig_a, sig_b;
  logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [3:0]  an_m;
  logic [7:0]  sig_m;
  logic        busy_m, done_m, ovf_m;
  int          sel, checks, failures;
  int          seen [4];
  vec_t        tbl [6];

  sseg_scan_ctrl #(.NUM_DIGITS(4), .VALUE_W(13), .REFRESH_DIV(8), .BLANK_CYC(2)) dut_a (
    .clk(clk), .rst(rst), .value(value_a), .mode(mode), .dp_in(dp_a), .lzb(lzb), .update(update_a),
    .busy(busy_a), .done(done_a), .overflow(ovf_a), .sseg_an(an_a), .sseg_sig(sig_a));

  sseg_scan_ctrl #(.NUM_DIGITS(2), .VALUE_W(8), .REFRESH_DIV(8), .BLANK_CYC(2)) dut_b (
    .clk(clk), .rst(rst), .value(value_b), .mode(mode), .dp_in(dp_b), .lzb(lzb), .update(update_b),
    .busy(busy_b), .done(done_b), .overflow(ovf_b), .sseg_an(an_b), .sseg_sig(sig_b));

  assign an_m   = sel == 1 ? {2'b11, an_b} : an_a;
  assign sig_m  = sel == 1 ? sig_b : sig_a;
  assign busy_m = sel == 1 ? busy_b : busy_a;
  assign done_m = sel == 1 ? done_b : done_a;
  assign ovf_m  = sel == 1 ? ovf_b : ovf_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_sig(int v, bit m, int dp, bit l, int k, int nd);
    int d [8];
    int t, msd, base;
    base = m ? 10 : 16;
    t = v;
    msd = 0;
    for (int i = 0; i < nd; i++) begin
      d[i] = t % base;
      t = t / base;
      if (d[i] != 0) msd = i;
    end
    if (t != 0) return 'hBF;
    if (l && k > msd) return NL;
    return int'({~dp[k], SEGTAB[d[k]]});
  endfunction

  function automatic int exp_ovf(int v, bit m, int nd);
    int t;
    t = v;
    for (int i = 0; i < nd; i++) t = t / (m ? 10 : 16);
    return t != 0 ? 1 : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_update(input int v, input bit m, input int dp, input bit l);
    @(negedge clk);
    value_a  = v[12:0];
    value_b  = v[7:0];
    dp_a     = dp[3:0];
    dp_b     = dp[1:0];
    mode     = m;
    lzb      = l;
    update_a = sel == 0;
    update_b = sel == 1;
    @(negedge clk);
    update_a = 1'b0;
    update_b = 1'b0;
  endtask

  task automatic run_conv(input string tag, input int lat);
    int n;
    bit bok;
    n = 1;
    bok = 1'b1;
    while (!done_m && n < 100) begin
      if (!busy_m) bok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_busy_held"}, int'(bok & busy_m), 1);
    @(negedge clk);
    chk({tag, "_busy_drop"}, int'(busy_m), 0);
    @(negedge clk);
  endtask

  task automatic capture(input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < 4; k++) seen[k] = NL;
    repeat (32) begin
      @(negedge clk);
      if (an_m == 4'hF) begin
        if (sig_m != 8'hFF) bad++;
      end else if ($countones(~an_m) != 1) bad++;
      else for (int k = 0; k < 4; k++) if (!an_m[k]) seen[k] = int'(sig_m);
    end
    chk({tag, "_scan_shape"}, bad, 0);
  endtask

  task automatic model_check(input string tag, input int v, input bit m, input int dp, input bit l);
    int nd;
    nd = sel == 1 ? 2 : 4;
    capture(tag);
    for (int k = 0; k < nd; k++) chk($sformatf("%s_d%0d", tag, k), seen[k], exp_sig(v, m, dp, l, k, nd));
    chk({tag, "_ovf"}, int'(ovf_m), exp_ovf(v, m, nd));
  endtask

  task automatic convert_model(input string tag, input int v, input bit m, input int dp, input bit l);
    do_update(v, m, dp, l);
    run_conv(tag, m ? (sel == 1 ? 9 : 14) : 2);
    model_check(tag, v, m, dp, l);
  endtask

  task automatic check_release(input string tag);
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      chk($sformatf("%s_an_c%0d", tag, n), int'(an_a), (n >= 3 && n <= 8) ? 'hE : 'hF);
      if (n == 3) chk({tag, "_sig_zero"}, int'(sig_a), 'hC0);
    end
  endtask

  initial begin
    int t1, t2, dones;
    bit bok;
    checks = 0; failures = 0; sel = 0;
    rst = 1'b0; mode = 1'b0; lzb = 1'b0; update_a = 1'b0; update_b = 1'b0;
    value_a = '0; value_b = '0; dp_a = '0; dp_b = '0;
    tbl[0] = {1'b1, 13'd1234,  4'h0, 1'b0, 9'h0F9, 9'h0A4, 9'h0B0, 9'h099};
    tbl[1] = {1'b0, 13'h00AB,  4'h0, 1'b1, 9'h100, 9'h100, 9'h088, 9'h083};
    tbl[2] = {1'b0, 13'h1F00,  4'h5, 1'b1, 9'h0F9, 9'h00E, 9'h0C0, 9'h040};
    tbl[3] = {1'b1, 13'd0,     4'hF, 1'b1, 9'h100, 9'h100, 9'h100, 9'h040};
    tbl[4] = {1'b1, 13'd8191,  4'h8, 1'b0, 9'h000, 9'h0F9, 9'h090, 9'h0F9};
    tbl[5] = {1'b1, 13'd305,   4'h0, 1'b1, 9'h100, 9'h0B0, 9'h0C0, 9'h092};
    repeat (2) @(negedge clk);
    chk("rst_an", int'(an_a), 'hF);
    chk("rst_sig", int'(sig_a), 'hFF);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_ovf", int'(ovf_a), 0);
    rst = 1'b1;
    check_release("rel1");
    repeat (4) @(negedge clk);
    chk("midscan_an", int'(an_a), 'hD);
    #2 rst = 1'b0;
    #1;
    chk("async_an", int'(an_a), 'hF);
    chk("async_sig", int'(sig_a), 'hFF);
    @(negedge clk);
    rst = 1'b1;
    check_release("rel2");

    for (int i = 0; i < 6; i++) begin
      do_update(int'(tbl[i].v), tbl[i].m, int'(tbl[i].dp), tbl[i].l);
      run_conv($sformatf("vec%0d", i), tbl[i].m ? 14 : 2);
      capture($sformatf("vec%0d", i));
      for (int k = 0; k < 4; k++) chk($sformatf("vec%0d_d%0d", i, k), seen[k], int'(tbl[i].e[k]));
      chk($sformatf("vec%0d_ovf", i), int'(ovf_a), 0);
    end

    sel = 1;
    convert_model("b100", 100, 1'b1, 0, 1'b0);
    chk("b100_dash0", seen[0], 'hBF);
    chk("b100_dash1", seen[1], 'hBF);
    chk("b100_ovf_flag", int'(ovf_b), 1);
    convert_model("b99", 99, 1'b1, 0, 1'b0);
    chk("b99_d0", seen[0], 'h90);
    chk("b99_d1", seen[1], 'h90);
    chk("b99_ovf_flag", int'(ovf_b), 0);

    sel = 0;
    do_update(1234, 1'b1, 0, 1'b0);
    dones = 0; t1 = 0; t2 = 0; bok = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      if (n == 3) begin
        value_a = 13'd42; lzb = 1'b1; mode = 1'b1; dp_a = 4'h0; update_a = 1'b1;
      end else update_a = 1'b0;
      if (done_a) begin
        dones++;
        if (dones == 1) t1 = n; else t2 = n;
      end
      if (t2 == 0 && !busy_a) bok = 1'b0;
      @(negedge clk);
    end
    chk("pend_done_count", dones, 2);
    chk("pend_done1", t1, 14);
    chk("pend_done2", t2, 28);
    chk("pend_busy_cont", int'(bok), 1);
    chk("pend_busy_end", int'(busy_a), 0);
    model_check("pend42", 42, 1'b1, 0, 1'b1);

    do_update(1234, 1'b1, 0, 1'b0);
    repeat (4) @(negedge clk);
    chk("abort_busy_mid", int'(busy_a), 1);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", int'(busy_a), 0);
    chk("abort_an", int'(an_a), 'hF);
    chk("abort_sig", int'(sig_a), 'hFF);
    @(negedge clk);
    rst = 1'b1;
    model_check("abort_zero", 0, 1'b0, 0, 1'b0);
    chk("abort_no_restart", int'(busy_a), 0);
    convert_model("after_abort", 567, 1'b1, 2, 1'b0);

    for (int i = 0; i < 24; i++) begin
      int v, dp;
      bit m, l;
      sel = int'($urandom_range(0, 1));
      v   = sel == 1 ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 8191));
      m   = 1'($urandom_range(0, 1));
      l   = 1'($urandom_range(0, 1));
      dp  = int'($urandom_range(0, 15));
      convert_model($sformatf("rnd%0d", i), v, m, dp, l);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
